// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int          REG_AW           = 3;
    localparam logic [1:0]  FWD_REGFILE      = 2'b00;
    localparam logic [1:0]  FWD_EXMEM        = 2'b01;
    localparam logic [1:0]  FWD_MEMWB        = 2'b10;
    localparam logic [2:0]  MULTI_OP_DEFAULT = 3'b111;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : Operand-forwarding select for one ALU source (EX/MEM over MEM/WB).
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
    import pipe_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_wb_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_wb_i,
    output logic [1:0]        sel_o
);

    logic w_src_zero;

    assign w_src_zero = R0_ZERO && (src_i == '0);

    always_comb begin
        sel_o = FWD_REGFILE;
        if (!w_src_zero) begin
            if (mem_wb_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (wb_wb_i && (wb_rd_i == src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush/forwarding control and multi-cycle ALU sequencing.
//            Optional stall counter output enabled by HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int         MULTI_CYCLES = 4,
    parameter logic [2:0] MULTI_OP     = MULTI_OP_DEFAULT,
    parameter bit         R0_ZERO      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wb,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_alu_ctrl,
    input  logic              branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wb,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wb,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              fd_flush,
    output logic              de_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // The first MULTI-state cycle is the second EX cycle of the op.
    localparam logic [3:0] c_MULTI_INIT = 4'(MULTI_CYCLES - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       w_load_use;
    logic       w_multi_start;
    logic [1:0] w_fwd_a, w_fwd_b;

    fwd_sel #(.R0_ZERO(R0_ZERO)) u_fwd_a (
        .src_i    (id_rs1),
        .mem_rd_i (mem_rd),
        .mem_wb_i (mem_wb),
        .wb_rd_i  (wb_rd),
        .wb_wb_i  (wb_wb),
        .sel_o    (w_fwd_a)
    );

    fwd_sel #(.R0_ZERO(R0_ZERO)) u_fwd_b (
        .src_i    (id_rs2),
        .mem_rd_i (mem_rd),
        .mem_wb_i (mem_wb),
        .wb_rd_i  (wb_rd),
        .wb_wb_i  (wb_wb),
        .sel_o    (w_fwd_b)
    );

    assign fwd_a = reset ? FWD_REGFILE : w_fwd_a;
    assign fwd_b = reset ? FWD_REGFILE : w_fwd_b;

    assign w_multi_start = ex_valid && (ex_alu_ctrl == MULTI_OP);
    assign w_load_use    = ex_valid && ex_is_load && ex_wb
                         && !(R0_ZERO && (ex_rd == '0))
                         && (((ex_rd == id_rs1) && id_rs1_used)
                          || ((ex_rd == id_rs2) && id_rs2_used));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        busy     = 1'b0;
        if (reset) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (w_multi_start) begin
                        fd_en   = 1'b0;
                        de_en   = 1'b0;
                        em_en   = 1'b0;
                        busy    = 1'b1;
                        cnt_d   = c_MULTI_INIT;
                        state_d = MULTI;
                    end else if (w_load_use) begin
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end
                end
                MULTI: begin
                    if (cnt_q != '0) begin
                        fd_en = 1'b0;
                        de_en = 1'b0;
                        em_en = 1'b0;
                        busy  = 1'b1;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!fd_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
